// File: rtl/lifo_stack_pkg.sv
// Shared types and command decode for the lifo_stack operand stack.
// Optional feature macro: LIFO_STACK_ERR_EN (sticky over/underflow flag).
package lifo_stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_PUSH,
        CMD_POP,
        CMD_TOS,
        CMD_REPLACE
    } cmd_e;

    // Resolve raw request lines into one effective command.
    // Pop beats tos; push+pop on an empty stack degrades to a push.
    function automatic cmd_e cmd_decode(
        input logic push,
        input logic pop,
        input logic tos,
        input logic empty,
        input logic full
    );
        cmd_e c;
        c = CMD_NONE;
        priority case (1'b1)
            (pop && !empty):         c = push ? CMD_REPLACE : CMD_POP;
            (push && !full):         c = CMD_PUSH;
            (tos && !empty && !push): c = CMD_TOS;
            default:                 c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Command/data bundle between the datapath and lifo_stack.
// Optional feature macro: LIFO_STACK_ERR_EN adds the err line.
interface lifo_stack_if
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             tos;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             empty;
    logic             full;
`ifdef LIFO_STACK_ERR_EN
    logic             err;
`endif

    modport master (
        output tos,
        output push,
        output pop,
        output d_in,
        input  d_out,
        input  empty,
        input  full
`ifdef LIFO_STACK_ERR_EN
        ,
        input  err
`endif
    );

    modport slave (
        input  tos,
        input  push,
        input  pop,
        input  d_in,
        output d_out,
        output empty,
        output full
`ifdef LIFO_STACK_ERR_EN
        ,
        output err
`endif
    );

endinterface

// File: rtl/lifo_stack_mem.sv
// DEPTH x WIDTH register array: one write port, one async read port.
// Contents are intentionally not reset.
module lifo_stack_mem
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO operand stack with registered read data.
// Optional feature macro: LIFO_STACK_ERR_EN (sticky err output).
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    lifo_stack_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);

    logic [PTR_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] top_data;
    logic             we;
    logic             empty;
    logic             full;
    cmd_e             cmd;

    assign empty = (count_q == '0);
    assign full  = (count_q == PTR_W'(DEPTH));

    assign cmd = cmd_decode(bus.push, bus.pop, bus.tos, empty, full);

    // Wraps harmlessly when empty; only used for non-empty commands.
    assign top_addr = AW'(count_q) - AW'(1);
    assign we       = (cmd == CMD_PUSH) || (cmd == CMD_REPLACE);
    assign wr_addr  = (cmd == CMD_REPLACE) ? top_addr : AW'(count_q);

    lifo_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_addr),
        .wdata_i (bus.d_in),
        .raddr_i (top_addr),
        .rdata_o (top_data)
    );

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        unique case (cmd)
            CMD_PUSH:    count_d = count_q + PTR_W'(1);
            CMD_POP: begin
                count_d = count_q - PTR_W'(1);
                dout_d  = top_data;
            end
            CMD_TOS:     dout_d = top_data;
            CMD_REPLACE: dout_d = top_data;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.d_out = dout_q;
    assign bus.empty = empty;
    assign bus.full  = full;

`ifdef LIFO_STACK_ERR_EN
    logic err_q;
    logic ovf;
    logic unf;

    assign ovf = bus.push && !bus.pop && full;
    assign unf = (bus.pop || bus.tos) && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (ovf || unf) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Randomized self-checking bench for lifo_stack against a queue model.
// Optional feature macro: LIFO_STACK_ERR_EN also checks err.
module tb_lifo_stack;

    localparam int W = 8;
    localparam int D = 16;

    logic clk;
    logic rst_n;

    lifo_stack_if #(.WIDTH(W)) bus ();

    lifo_stack #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, 32'(bus.d_out), 32'(m_dout));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == D));
`ifdef LIFO_STACK_ERR_EN
        chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
`endif
    endtask

    task automatic model(input bit pu, input bit po, input bit t,
                         input logic [W-1:0] din);
        bit emp;
        emp = (q.size() == 0);
        if (pu && !po && q.size() == D) m_err = 1'b1;
        if ((po || t) && emp) m_err = 1'b1;
        if (po && !emp) begin
            m_dout = q[$];
            void'(q.pop_back());
            if (pu) q.push_back(din);
        end else if (pu) begin
            if (q.size() < D) q.push_back(din);
        end else if (t && !emp) begin
            m_dout = q[$];
        end
    endtask

    task automatic step(input string tag, input bit pu, input bit po,
                        input bit t, input logic [W-1:0] din);
        bus.push = pu;
        bus.pop  = po;
        bus.tos  = t;
        bus.d_in = din;
        @(posedge clk);
        model(pu, po, t, din);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_err  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.tos  = 1'b0;
        bus.d_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("idle", 0, 0, 0, 8'h00);
        chk("idle.const", 32'(bus.d_out), 32'h00);
        step("push80", 1, 0, 0, 8'h80);
        step("push55", 1, 0, 0, 8'h55);
        chk("push55.const", 32'(bus.d_out), 32'h00);
        step("tos1", 0, 0, 1, 8'h00);
        step("tos2", 0, 0, 1, 8'h00);
        chk("tos2.const", 32'(bus.d_out), 32'h55);
        step("pop1", 0, 1, 0, 8'h00);
        chk("pop1.const", 32'(bus.d_out), 32'h55);
        step("pop2", 0, 1, 0, 8'h00);
        chk("pop2.const", 32'(bus.d_out), 32'h80);
        step("pop3", 0, 1, 0, 8'h00);
        chk("pop3.const", 32'(bus.d_out), 32'h80);
        chk("pop3.empty", 32'(bus.empty), 32'h1);

        for (int i = 1; i <= D; i++) step("fill", 1, 0, 0, W'(i));
        chk("fill.full", 32'(bus.full), 32'h1);
        step("ovf", 1, 0, 0, 8'hFF);
        step("popfull", 0, 1, 0, 8'h00);
        chk("popfull.const", 32'(bus.d_out), 32'h10);
        for (int i = 0; i < D - 1; i++) step("drain", 0, 1, 0, 8'h00);

        step("pushAA", 1, 0, 0, 8'hAA);
        step("repl", 1, 1, 0, 8'hBB);
        chk("repl.const", 32'(bus.d_out), 32'hAA);
        step("tosBB", 0, 0, 1, 8'h00);
        chk("tosBB.const", 32'(bus.d_out), 32'hBB);
        step("popBB", 0, 1, 0, 8'h00);
        step("pp_empty", 1, 1, 0, 8'h3C);
        step("tp_push", 1, 0, 1, 8'h4D);
        step("pt_pop", 0, 1, 1, 8'h00);

        for (int i = 0; i < 5; i++) step("burst", 1, 0, 0, W'(8'hC0 + i));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.dout", 32'(bus.d_out), 32'h00);
        chk("arst.empty", 32'(bus.empty), 32'h1);
        chk("arst.full", 32'(bus.full), 32'h0);
        bus.push = 1'b1;
        @(posedge clk);
        #1;
        check_all("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        for (int p = 0; p < 18; p++) begin
            int pw;
            pw = (p % 3 == 0) ? 75 : ((p % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 100; i++) begin
                bit pu, po, t;
                pu = ($urandom_range(99) < pw);
                po = ($urandom_range(99) < 100 - pw);
                t  = ($urandom_range(99) < 25);
                step("rand", pu, po, t, W'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
